// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the iterative divider controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Result bus carries {remainder, quotient}, each DATA_W wide.
  localparam int DivResultMult = 2;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step over the {remainder, quotient} accumulator.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0]   acc,
  input  logic [DATA_W-1:0]   divisor,
  output logic [DATA_W-1:0]   diff,
  output logic                nonneg,
  output logic [2*DATA_W:0]   acc_next
);

  logic signed [DATA_W+1:0] trial;

  // Remainder field lives in acc[2W:W]; shifting left pulls the next dividend bit in.
  always_comb begin
    trial    = $signed({1'b0, acc[2*DATA_W-1:DATA_W-1]}) - $signed({2'b00, divisor});
    nonneg   = acc[2*DATA_W] | ~trial[DATA_W+1];
    diff     = trial[DATA_W-1:0];
    acc_next = nonneg ? {trial[DATA_W:0], acc[DATA_W-2:0], 1'b1}
                      : {acc[2*DATA_W-1:0], 1'b0};
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for the shared radix-2 restoring divider behind DIV/DIVU.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              div_start,
  input  logic                              div_signed,
  input  logic [DATA_W-1:0]                 opdata1,
  input  logic [DATA_W-1:0]                 opdata2,
  input  logic                              annul,
  output logic [DivResultMult*DATA_W-1:0]   result,
  output logic                              result_ready,
  output logic                              stallreq_for_div,
  output logic                              busy
);

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x,
                                                  input logic en);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    return (en && x[DATA_W-1]) ? $unsigned(neg) : $unsigned(x);
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] x,
                                                   input logic neg);
    return neg ? (~x + DATA_W'(1)) : x;
  endfunction

  div_state_t                        state, state_next;
  logic [CNT_W-1:0]                  cnt, cnt_next;
  logic [DivResultMult*DATA_W-1:0]   result_next;
  logic [2*DATA_W:0]                 acc;
  logic [DATA_W-1:0]                 divisor;
  logic                              neg_quo, neg_rem;
  logic [DATA_W-1:0]                 step_diff;
  logic                              step_nonneg;
  logic [2*DATA_W:0]                 step_next;
  logic [DATA_W-1:0]                 quo_fix, rem_fix;
  logic                              start_ok, last_step;

  div_step #(.DATA_W(DATA_W)) u_step (
    .acc      (acc),
    .divisor  (divisor),
    .diff     (step_diff),
    .nonneg   (step_nonneg),
    .acc_next (step_next)
  );

  assign start_ok  = (div_start == DivStart) & ~annul;
  assign last_step = (cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    state_next  = state;
    cnt_next    = '0;
    result_next = result;
    // On the final step the remainder comes straight from the subtractor when it fits.
    rem_fix = apply_sign(step_nonneg ? step_diff : step_next[2*DATA_W-1:DATA_W], neg_rem);
    quo_fix = apply_sign(step_next[DATA_W-1:0], neg_quo);
    case (state)
      DivFree: begin
        if (start_ok) state_next = (opdata2 == '0) ? DivByZero : DivOn;
      end
      DivByZero: begin
        if (annul) begin
          state_next = DivFree;
        end else begin
          state_next  = DivEnd;
          result_next = {acc[DATA_W-1:0], {DATA_W{1'b1}}};
        end
      end
      DivOn: begin
        if (annul) begin
          state_next = DivFree;
        end else if (last_step) begin
          state_next  = DivEnd;
          result_next = {rem_fix, quo_fix};
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DivEnd: begin
        if (annul || div_start == DivStop) state_next = DivFree;
      end
      default: state_next = DivFree;
    endcase
  end

  assign result_ready     = (state == DivEnd) ? DivResultReady : DivResultNotReady;
  assign busy             = (state != DivFree);
  assign stallreq_for_div = start_ok & (state != DivEnd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DivFree;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      result <= result_next;
    end
  end

  // Operand capture: a zero divisor keeps the raw dividend for the {dividend, all-ones} result.
  always_ff @(posedge clk) begin
    if (state == DivFree && start_ok) begin
      if (opdata2 == '0) acc <= {{(DATA_W+1){1'b0}}, opdata1};
      else               acc <= {{(DATA_W+1){1'b0}}, magnitude(opdata1, div_signed)};
      divisor <= magnitude(opdata2, div_signed);
      neg_quo <= div_signed & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
      neg_rem <= div_signed & opdata1[DATA_W-1];
    end else if (state == DivOn) begin
      acc <= step_next;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed plus randomized bench for div_ctrl against an arithmetic divide model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        result_ready;
  logic        stallreq_for_div;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .div_start        (div_start),
    .div_signed       (div_signed),
    .opdata1          (opdata1),
    .opdata2          (opdata2),
    .annul            (annul),
    .result           (result),
    .result_ready     (result_ready),
    .stallreq_for_div (stallreq_for_div),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {HI = remainder, LO = quotient}, truncating division as DIV/DIVU define it.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the controller idle; that cycle is the start cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input int annul_at);
    logic [63:0] exp_res, prev_res;
    int lat, exp_lat;
    logic done;
    exp_res  = model(a, b, s);
    exp_lat  = (b == 32'd0) ? 2 : 33;
    prev_res = result;
    done     = 1'b0;
    div_start  = 1'b1;
    div_signed = s;
    opdata1    = a;
    opdata2    = b;
    annul      = 1'b0;
    #1;
    check("start_stall", stallreq_for_div, 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      opdata1    = $urandom;
      opdata2    = $urandom;
      div_signed = 1'($urandom);
      if (result_ready) begin
        done = 1'b1;
      end else if (annul_at == lat) begin
        annul = 1'b1;
        #1;
        check("annul_stall", stallreq_for_div, 0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        check("annul_busy", busy, 0);
        check("annul_ready", result_ready, 0);
        check("annul_result", result, prev_res);
        return;
      end else begin
        check("run_stall_busy", {stallreq_for_div, busy}, 2'b11);
      end
    end
    check("latency", lat, exp_lat);
    check("result", result, exp_res);
    check("done_stall", stallreq_for_div, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_ready", result_ready, 1);
      check("hold_result", result, exp_res);
    end
    div_start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy_ready", {busy, result_ready}, 2'b00);
    check("idle_result", result, exp_res);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 0);
    check("reset_ready", result_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_stall", stallreq_for_div, 0);
    div_start = 1'b1; opdata1 = 32'd9; opdata2 = 32'd3;
    @(posedge clk);
    #1;
    check("rst_wins_busy", busy, 0);
    div_start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_div(32'd100, 32'd7, 1'b0, 0, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0);
    run_div(32'd5, 32'd0, 1'b0, 0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
    run_div(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0, 0);
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, 0);
    run_div(32'd12345, 32'd67, 1'b0, 0, 10);
    run_div(32'd20, 32'd3, 1'b0, 0, 0);
    run_div(32'hFFFF_FC18, 32'd7, 1'b1, 5, 0);

    // Asynchronous reset between edges while a divide is running.
    div_start = 1'b1; div_signed = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd9;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    div_start = 1'b0;
    #1;
    check("async_rst_result", result, 0);
    check("async_rst_ready", result_ready, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_stall", stallreq_for_div, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_div(32'd1000, 32'd9, 1'b0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom;
      endcase
      if (rb == 32'd0 && i[0]) rb = 32'd1;
      rs = 1'($urandom);
      run_div(ra, rb, rs, $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
